// File: rtl/com_csr_csr2apb_if.sv
// Bus bundles for the CSR-to-APB master bridge.
// The CSR bundle carries the single-request handshake from the requester; the
// APB bundle carries the APB3/APB4 master signals toward the peripheral.

interface com_csr_csr2apb_csr_if #(
    parameter int AW_CSR = 16,
    parameter int DW     = 32
) ();
    localparam int SW = DW / 8;

    logic              csr_valid;
    logic              csr_write;
    logic [AW_CSR-1:0] csr_addr;
    logic [DW-1:0]     csr_wdata;
    logic [SW-1:0]     csr_wstrb;
    logic              csr_ready;
    logic [DW-1:0]     csr_rdata;
    logic              csr_err;

    // Requester side.
    modport master (
        output csr_valid, csr_write, csr_addr, csr_wdata, csr_wstrb,
        input  csr_ready, csr_rdata, csr_err
    );

    // Bridge side.
    modport slave (
        input  csr_valid, csr_write, csr_addr, csr_wdata, csr_wstrb,
        output csr_ready, csr_rdata, csr_err
    );
endinterface

interface com_csr_csr2apb_apb_if #(
    parameter int AW_APB = 32,
    parameter int DW     = 32
) ();
    localparam int SW = DW / 8;

    logic [AW_APB-1:0] PADDR;
    logic [2:0]        PPROT;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;

    // Bridge side.
    modport master (
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    // Peripheral side.
    modport slave (
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/com_csr_csr2apb.sv
// CSR-to-APB master bridge.
// Takes one CSR request at a time, runs the matching APB SETUP/ACCESS
// transfer, and returns read data plus an error flag with a one-cycle
// csr_ready pulse. A programmable ACCESS-phase timeout aborts transfers to a
// slave that never raises PREADY. Every output is driven from a register.

module com_csr_csr2apb #(
    parameter int                AW_CSR       = 16,
    parameter int                DW           = 32,
    parameter int                SW           = DW / 8,
    parameter int                AW_APB       = 32,
    parameter logic [AW_APB-1:0] APB_BASEADDR = '0,
    parameter logic [2:0]        PPROT_VAL    = 3'b000,
    parameter int                TIMEOUT      = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    com_csr_csr2apb_csr_if.slave         csr,
    com_csr_csr2apb_apb_if.master        apb,
    output logic                         err_timeout
);

    // Wait counter spans 0..TIMEOUT; keep at least one bit when disabled.
    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW_APB-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DW-1:0]     pwdata_q, pwdata_d;
    logic [SW-1:0]     pstrb_q, pstrb_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              csr_ready_q, csr_ready_d;
    logic [DW-1:0]     csr_rdata_q, csr_rdata_d;
    logic              csr_err_q, csr_err_d;
    logic              err_timeout_q, err_timeout_d;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        csr_ready_d   = 1'b0;
        csr_rdata_d   = csr_rdata_q;
        csr_err_d     = csr_err_q;
        err_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (csr.csr_valid) begin
                    // Base offset wraps naturally at AW_APB bits.
                    paddr_d  = APB_BASEADDR + AW_APB'(csr.csr_addr);
                    pwrite_d = csr.csr_write;
                    pwdata_d = csr.csr_wdata;
                    pstrb_d  = csr.csr_write ? csr.csr_wstrb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end

            ACCESS: begin
                if (apb.PREADY) begin
                    // A real response always beats a timeout landing on the same cycle.
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    csr_ready_d = 1'b1;
                    csr_err_d   = apb.PSLVERR;
                    csr_rdata_d = (!pwrite_q && !apb.PSLVERR) ? apb.PRDATA : '0;
                    state_d     = DONE;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        csr_ready_d   = 1'b1;
                        csr_err_d     = 1'b1;
                        csr_rdata_d   = '0;
                        err_timeout_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                // Completion data is only meaningful during the csr_ready pulse.
                csr_rdata_d = '0;
                csr_err_d   = 1'b0;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            csr_ready_q   <= 1'b0;
            csr_rdata_q   <= '0;
            csr_err_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            csr_ready_q   <= csr_ready_d;
            csr_rdata_q   <= csr_rdata_d;
            csr_err_q     <= csr_err_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign apb.PADDR     = paddr_q;
    assign apb.PPROT     = PPROT_VAL;
    assign apb.PSEL      = psel_q;
    assign apb.PENABLE   = penable_q;
    assign apb.PWRITE    = pwrite_q;
    assign apb.PWDATA    = pwdata_q;
    assign apb.PSTRB     = pstrb_q;
    assign csr.csr_ready = csr_ready_q;
    assign csr.csr_rdata = csr_rdata_q;
    assign csr.csr_err   = csr_err_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_com_csr_csr2apb.sv
// Self-checking bench for com_csr_csr2apb: directed vector table, hand-written
// back-to-back / protocol-violation / mid-transfer reset sequences, and random
// transfers checked against a cycle-count model of the bridge.

module tb_com_csr_csr2apb;

    localparam int          AW_CSR = 16;
    localparam int          DW     = 32;
    localparam int          SW     = DW / 8;
    localparam int          AW_APB = 32;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [2:0]  PPROT  = 3'b000;
    localparam int          TO     = 8;
    localparam int          NEVER  = 1000;

    logic clk = 1'b0;
    logic rst_n;
    logic err_timeout;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    com_csr_csr2apb_csr_if #(.AW_CSR(AW_CSR), .DW(DW)) csr_bus ();
    com_csr_csr2apb_apb_if #(.AW_APB(AW_APB), .DW(DW)) apb_bus ();

    com_csr_csr2apb #(
        .AW_CSR(AW_CSR), .DW(DW), .SW(SW), .AW_APB(AW_APB),
        .APB_BASEADDR(BASE), .PPROT_VAL(PPROT), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .csr(csr_bus),
        .apb(apb_bus),
        .err_timeout(err_timeout)
    );

    // Behavioural APB slave: PREADY after slave_waits wait states in ACCESS.
    int          slave_waits = 0;
    logic [31:0] slave_prdata = '0;
    logic        slave_slverr = 1'b0;
    int          acc_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (apb_bus.PSEL && apb_bus.PENABLE && !apb_bus.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign apb_bus.PREADY  = apb_bus.PSEL && apb_bus.PENABLE && (acc_cnt >= slave_waits);
    assign apb_bus.PRDATA  = slave_prdata;
    assign apb_bus.PSLVERR = slave_slverr;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
    } txn_t;

    typedef struct {
        logic [31:0] paddr;
        logic [3:0]  pstrb;
        int          ready_k;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    typedef struct {
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        int          psel_k;
        int          penable_k;
        int          ready_k;
        int          psel_cyc;
        logic [31:0] rdata;
        logic        err;
        logic        to;
        logic        proto_ok;
        logic        pulse_ok;
        logic        hold_ok;
    } obs_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: transfer outcome from the slave's wait count and response.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        int   access_cycles;
        e.to          = (t.waits >= TO);
        access_cycles = e.to ? TO : t.waits + 1;
        e.paddr       = BASE + {16'h0000, t.addr};
        e.pstrb       = t.wr ? t.wstrb : 4'h0;
        e.ready_k     = 2 + access_cycles;
        e.err         = e.to | t.slverr;
        e.rdata       = (e.to || t.wr || t.slverr) ? 32'h0 : t.prdata;
        return e;
    endfunction

    function automatic vec_t mkvec(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] wstrb, input int waits, input logic [31:0] prdata,
                                   input logic slverr, input logic [31:0] e_paddr, input logic [3:0] e_pstrb,
                                   input int e_ready, input logic [31:0] e_rdata, input logic e_err,
                                   input logic e_to);
        vec_t v;
        v.t.wr = wr; v.t.addr = addr; v.t.wdata = wdata; v.t.wstrb = wstrb;
        v.t.waits = waits; v.t.prdata = prdata; v.t.slverr = slverr;
        v.e.paddr = e_paddr; v.e.pstrb = e_pstrb; v.e.ready_k = e_ready;
        v.e.rdata = e_rdata; v.e.err = e_err; v.e.to = e_to;
        return v;
    endfunction

    // Issue one request (caller is at a negedge) and observe it to completion.
    task automatic run_txn(input txn_t t, input bit drop_early, output obs_t o);
        bit done = 0;
        o.paddr = '0; o.pwrite = 0; o.pwdata = '0; o.pstrb = '0;
        o.psel_k = -1; o.penable_k = -1; o.ready_k = -1; o.psel_cyc = -1;
        o.rdata = '0; o.err = 0; o.to = 0;
        o.proto_ok = 1; o.pulse_ok = 0; o.hold_ok = 0;
        slave_waits  = t.waits;
        slave_prdata = t.prdata;
        slave_slverr = t.slverr;
        csr_bus.csr_valid = 1'b1;
        csr_bus.csr_write = t.wr;
        csr_bus.csr_addr  = t.addr;
        csr_bus.csr_wdata = t.wdata;
        csr_bus.csr_wstrb = t.wstrb;
        for (int k = 1; k <= 400 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1 && drop_early) begin
                csr_bus.csr_valid = 1'b0;
                csr_bus.csr_write = ~t.wr;
                csr_bus.csr_addr  = ~t.addr;
                csr_bus.csr_wdata = ~t.wdata;
                csr_bus.csr_wstrb = ~t.wstrb;
            end
            if (apb_bus.PSEL && o.psel_k < 0) begin
                o.psel_k   = k;
                o.psel_cyc = cyc;
                o.paddr    = apb_bus.PADDR;
                o.pwrite   = apb_bus.PWRITE;
                o.pwdata   = apb_bus.PWDATA;
                o.pstrb    = apb_bus.PSTRB;
            end
            if (apb_bus.PENABLE && o.penable_k < 0) o.penable_k = k;
            if (apb_bus.PENABLE && !apb_bus.PSEL) o.proto_ok = 0;
            if (apb_bus.PSEL && (apb_bus.PADDR !== o.paddr || apb_bus.PWRITE !== o.pwrite ||
                                 apb_bus.PWDATA !== o.pwdata || apb_bus.PSTRB !== o.pstrb))
                o.proto_ok = 0;
            if (err_timeout && !csr_bus.csr_ready) o.proto_ok = 0;
            if (csr_bus.csr_ready) begin
                if (apb_bus.PSEL || apb_bus.PENABLE) o.proto_ok = 0;
                o.ready_k = k;
                o.rdata   = csr_bus.csr_rdata;
                o.err     = csr_bus.csr_err;
                o.to      = err_timeout;
                done      = 1;
                csr_bus.csr_valid = 1'b0;
            end
        end
        if (!done) begin
            csr_bus.csr_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            o.pulse_ok = !csr_bus.csr_ready && !err_timeout && !apb_bus.PSEL && !apb_bus.PENABLE;
            o.hold_ok  = (apb_bus.PADDR === o.paddr) && (apb_bus.PWRITE === o.pwrite) &&
                         (apb_bus.PWDATA === o.pwdata) && (apb_bus.PSTRB === o.pstrb);
        end
    endtask

    task automatic verify(input string tag, input txn_t t, input exp_t e, input obs_t o);
        check({tag, ".paddr"},   o.paddr, e.paddr);
        check({tag, ".pwrite"},  o.pwrite, t.wr);
        check({tag, ".pwdata"},  o.pwdata, t.wdata);
        check({tag, ".pstrb"},   o.pstrb, e.pstrb);
        check({tag, ".psel_at"}, o.psel_k, 1);
        check({tag, ".pen_at"},  o.penable_k, 2);
        check({tag, ".rdy_at"},  o.ready_k, e.ready_k);
        check({tag, ".rdata"},   o.rdata, e.rdata);
        check({tag, ".err"},     o.err, e.err);
        check({tag, ".tmo"},     o.to, e.to);
        check({tag, ".proto"},   o.proto_ok, 1'b1);
        check({tag, ".pulse"},   o.pulse_ok, 1'b1);
        check({tag, ".hold"},    o.hold_ok, 1'b1);
    endtask

    function automatic logic [127:0] out_bundle();
        return {apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PSTRB, csr_bus.csr_ready,
                csr_bus.csr_err, err_timeout, apb_bus.PADDR, apb_bus.PWDATA, csr_bus.csr_rdata};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        obs_t o, o2;
        txn_t t;
        bit   seen;

        vecs[0] = mkvec(1, 16'h0010, 32'hA5A5_5A5A, 4'hF, 0, 32'h0, 0,
                        32'h4000_0010, 4'hF, 3, 32'h0, 0, 0);
        vecs[1] = mkvec(0, 16'h0020, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 0,
                        32'h4000_0020, 4'h0, 6, 32'hDEAD_BEEF, 0, 0);
        vecs[2] = mkvec(0, 16'h0030, 32'h0, 4'h0, 0, 32'h1234_5678, 1,
                        32'h4000_0030, 4'h0, 3, 32'h0, 1, 0);
        vecs[3] = mkvec(0, 16'h0040, 32'h0, 4'h0, NEVER, 32'h5555_AAAA, 0,
                        32'h4000_0040, 4'h0, 10, 32'h0, 1, 1);
        vecs[4] = mkvec(1, 16'h0044, 32'h0000_0001, 4'h3, 0, 32'h0, 0,
                        32'h4000_0044, 4'h3, 3, 32'h0, 0, 0);
        vecs[5] = mkvec(0, 16'hFFFF, 32'h7777_0000, 4'hF, 7, 32'hCAFE_F00D, 0,
                        32'h4000_FFFF, 4'h0, 10, 32'hCAFE_F00D, 0, 0);
        vecs[6] = mkvec(1, 16'h0100, 32'h0BAD_CAFE, 4'h5, 8, 32'h0, 0,
                        32'h4000_0100, 4'h5, 10, 32'h0, 1, 1);
        vecs[7] = mkvec(1, 16'h0002, 32'h1357_9BDF, 4'h8, 2, 32'hFFFF_FFFF, 1,
                        32'h4000_0002, 4'h8, 5, 32'h0, 1, 0);
        vecs[8] = mkvec(0, 16'h0004, 32'h0, 4'h0, 1, 32'h89AB_CDEF, 0,
                        32'h4000_0004, 4'h0, 4, 32'h89AB_CDEF, 0, 0);

        rst_n = 1'b0;
        csr_bus.csr_valid = 1'b0;
        csr_bus.csr_write = 1'b0;
        csr_bus.csr_addr  = '0;
        csr_bus.csr_wdata = '0;
        csr_bus.csr_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.outputs", out_bundle(), 128'h0);
        check("reset.pprot", apb_bus.PPROT, PPROT);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].t, 0, o);
            verify($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, o);
        end

        // Back-to-back writes: second PSEL rises exactly 4 cycles after the first.
        t = vecs[0].t; t.addr = 16'h0004; t.wdata = 32'h0000_0004; t.waits = 0;
        run_txn(t, 0, o);
        verify("b2b_a", t, model(t), o);
        t.addr = 16'h0008; t.wdata = 32'h0000_0008;
        run_txn(t, 0, o2);
        verify("b2b_b", t, model(t), o2);
        check("b2b.interval", o2.psel_cyc - o.psel_cyc, 4);

        // csr_valid dropped and fields scrambled right after sampling.
        t.wr = 0; t.addr = 16'h0050; t.wdata = 32'h2468_ACE0; t.wstrb = 4'h6;
        t.waits = 2; t.prdata = 32'h1111_2222; t.slverr = 0;
        run_txn(t, 1, o);
        verify("early_drop", t, model(t), o);

        // Asynchronous reset while in ACCESS.
        slave_waits = NEVER;
        slave_slverr = 1'b0;
        csr_bus.csr_valid = 1'b1;
        csr_bus.csr_write = 1'b1;
        csr_bus.csr_addr  = 16'h0060;
        csr_bus.csr_wdata = 32'hFEED_FACE;
        csr_bus.csr_wstrb = 4'hF;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        csr_bus.csr_valid = 1'b0;
        check("rst_mid.in_access", apb_bus.PENABLE, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.outputs", out_bundle(), 128'h0);
        check("rst_mid.pprot", apb_bus.PPROT, PPROT);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (csr_bus.csr_ready || apb_bus.PSEL) seen = 1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (csr_bus.csr_ready) seen = 1;
        check("rst_mid.no_ready", seen, 1'b0);
        t.wr = 0; t.addr = 16'h0070; t.wdata = 32'h0; t.wstrb = 4'h0;
        t.waits = 1; t.prdata = 32'h0F0F_F0F0; t.slverr = 0;
        run_txn(t, 0, o);
        verify("after_rst", t, model(t), o);

        // Random transfers against the reference model.
        for (int i = 0; i < 24; i++) begin
            t.wr     = 1'($urandom_range(0, 1));
            t.addr   = 16'($urandom);
            t.wdata  = $urandom;
            t.wstrb  = 4'($urandom);
            t.waits  = int'($urandom_range(0, 10));
            t.prdata = $urandom;
            t.slverr = ($urandom_range(0, 3) == 0);
            run_txn(t, 0, o);
            verify($sformatf("rnd%0d", i), t, model(t), o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
